// File: rtl/ram_arbiter.sv
// Purpose: two-core arbiter of I/D cache ports onto one RAM port; round-robin between cores, data before instr.
// Latency: 1 cycle to arbitrate (IDLE), then the grant holds until ramstate==ACCESS; 1 IDLE cycle between grants.
// Backpressure: losers and the owner see wait=1 until the cycle the owner's access completes; ERROR retries.
//
// Ports: CLK/nRST clock and async active-low reset; iREN/iaddr, dREN/dWEN/daddr/dstore per-core requests;
//        iwait/dwait/iload/dload per-core responses; ramREN/ramWEN/ramaddr/ramstore/ramload/ramstate RAM side;
//        owner/busy current grant; timeout_err sticky watchdog flag.
module ram_arbiter #(
    parameter int TIMEOUT = 255,
    parameter int WORD_W  = 32
) (
    input  logic                   CLK,
    input  logic                   nRST,
    input  logic [1:0]             iREN,
    input  logic [1:0][WORD_W-1:0] iaddr,
    input  logic [1:0]             dREN,
    input  logic [1:0]             dWEN,
    input  logic [1:0][WORD_W-1:0] daddr,
    input  logic [1:0][WORD_W-1:0] dstore,
    output logic [1:0]             iwait,
    output logic [1:0]             dwait,
    output logic [1:0][WORD_W-1:0] iload,
    output logic [1:0][WORD_W-1:0] dload,
    output logic                   ramREN,
    output logic                   ramWEN,
    output logic [WORD_W-1:0]      ramaddr,
    output logic [WORD_W-1:0]      ramstore,
    input  logic [WORD_W-1:0]      ramload,
    input  logic [1:0]             ramstate,
    output logic [1:0]             owner,
    output logic                   busy,
    output logic                   timeout_err
);
    // RAM status encoding: FREE=0, BUSY=1, ACCESS=2, ERROR=3; only ACCESS changes our behaviour.
    localparam logic [1:0] ACCESS = 2'd2;

    localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] TO_VAL  = CNT_W'(TIMEOUT);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t           state, state_nxt;
    logic [1:0]       owner_nxt;
    logic             last_core, last_core_nxt;
    logic [CNT_W-1:0] wd_cnt, wd_cnt_nxt;

    logic [1:0] dreq;
    logic [1:0] creq;
    logic       any_req;
    logic       pick_core;
    logic       pick_instr;
    logic       own_core;
    logic       own_instr;
    logic       own_req;
    logic       own_write;
    logic       done;

    assign dreq    = dREN | dWEN;
    assign creq    = dreq | iREN;
    assign any_req = |creq;

    // The core that did not complete last gets first pick; within a core, data beats instruction.
    assign pick_core  = creq[~last_core] ? ~last_core : last_core;
    assign pick_instr = ~dreq[pick_core];

    assign own_core  = owner[1];
    assign own_instr = owner[0];
    // The owner's live request: dropping it while granted aborts the transaction.
    assign own_req   = own_instr ? iREN[own_core] : dreq[own_core];
    // dREN and dWEN together is a write.
    assign own_write = ~own_instr & dWEN[own_core];

    assign busy = (state == GRANT);
    assign done = busy & own_req & (ramstate == ACCESS);

    // RAM side follows the owner's current inputs; enables are low outside GRANT or on abort.
    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = own_instr ? iaddr[own_core] : daddr[own_core];
        ramstore = dstore[own_core];
        if (busy && own_req) begin
            if (own_write) begin
                ramWEN = 1'b1;
            end else begin
                ramREN = 1'b1;
            end
        end
    end

    // Every pending request stalls except the one completing this cycle.
    always_comb begin
        iwait = iREN;
        dwait = dreq;
        if (done) begin
            if (own_instr) begin
                iwait[own_core] = 1'b0;
            end else begin
                dwait[own_core] = 1'b0;
            end
        end
    end

    assign iload = {2{ramload}};
    assign dload = {2{ramload}};

    always_comb begin
        state_nxt     = state;
        owner_nxt     = owner;
        last_core_nxt = last_core;
        case (state)
            IDLE: begin
                if (any_req) begin
                    state_nxt = GRANT;
                    owner_nxt = {pick_core, pick_instr};
                end
            end
            GRANT: begin
                if (!own_req) begin
                    state_nxt = IDLE;
                end else if (ramstate == ACCESS) begin
                    state_nxt     = IDLE;
                    last_core_nxt = own_core;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Watchdog counts GRANT cycles from zero at grant entry, saturating.
    always_comb begin
        wd_cnt_nxt = wd_cnt;
        if (state == IDLE) begin
            if (any_req) begin
                wd_cnt_nxt = '0;
            end
        end else if (wd_cnt != CNT_MAX) begin
            wd_cnt_nxt = wd_cnt + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state       <= IDLE;
            owner       <= '0;
            last_core   <= 1'b1;
            wd_cnt      <= '0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_nxt;
            owner       <= owner_nxt;
            last_core   <= last_core_nxt;
            wd_cnt      <= wd_cnt_nxt;
            timeout_err <= timeout_err | (busy & (wd_cnt_nxt >= TO_VAL));
        end
    end
endmodule

// File: tb/tb_ram_arbiter.sv
module tb_ram_arbiter;
    localparam int W = 32;
    localparam logic [1:0] FREE   = 2'd0;
    localparam logic [1:0] BUSY   = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;

    logic              CLK = 1'b0;
    logic              nRST = 1'b0;
    logic [1:0]        iREN, dREN, dWEN;
    logic [1:0][W-1:0] iaddr, daddr, dstore;
    logic [1:0]        iwait, dwait;
    logic [1:0][W-1:0] iload, dload;
    logic              ramREN, ramWEN;
    logic [W-1:0]      ramaddr, ramstore, ramload;
    logic [1:0]        ramstate;
    logic [1:0]        owner;
    logic              busy, timeout_err;

    ram_arbiter #(.TIMEOUT(4), .WORD_W(W)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate),
        .owner(owner), .busy(busy), .timeout_err(timeout_err)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [1:0]  owner;
        logic        ren;
        logic        wen;
        logic [31:0] addr;
        logic [31:0] store;
    } grant_t;

    typedef struct {
        int          core;
        logic        is_i;
        logic        ren;
        logic        wen;
        logic [31:0] addr;
        logic [31:0] store;
        int          lat;
        logic [1:0]  e_owner;
        logic        e_ren;
        logic        e_wen;
        logic [31:0] e_addr;
        logic [31:0] e_store;
    } vec_t;

    grant_t      exp_q[$];
    vec_t        vt[5];
    int          n_chk = 0, n_pass = 0;
    int          lat = 1, bcnt = 0, n_done = 0, idle_run = 0;
    logic        busy_q = 1'b0, chk_gap = 1'b0, gap_armed = 1'b0;
    logic [1:0]  done_d = '0, done_i = '0;
    logic [31:0] ram_data = 32'h0;

    assign ramload = ram_data;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic grant_t mkg(input logic [1:0] o, input logic r, input logic w,
                                   input logic [31:0] a, input logic [31:0] s);
        grant_t g;
        g.owner = o; g.ren = r; g.wen = w; g.addr = a; g.store = s;
        return g;
    endfunction

    function automatic vec_t mkv(input int core, input logic is_i, input logic ren, input logic wen,
                                 input logic [31:0] addr, input logic [31:0] store, input int l,
                                 input logic [1:0] eo, input logic er, input logic ew,
                                 input logic [31:0] ea, input logic [31:0] es);
        vec_t v;
        v.core = core; v.is_i = is_i; v.ren = ren; v.wen = wen; v.addr = addr; v.store = store;
        v.lat = l; v.e_owner = eo; v.e_ren = er; v.e_wen = ew; v.e_addr = ea; v.e_store = es;
        return v;
    endfunction

    // Sampled at the falling edge: checks each new grant against the scoreboard and records completions.
    task automatic monitor();
        grant_t e;
        if (busy && !busy_q) begin
            if (chk_gap && gap_armed) chk("idle_gap", 32'(idle_run), 32'd1);
            gap_armed = chk_gap;
            idle_run  = 0;
            if (exp_q.size() == 0) begin
                chk("unexpected_grant", 32'(owner), 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                chk("grant_owner", 32'(owner), 32'(e.owner));
                chk("grant_ramREN", 32'(ramREN), 32'(e.ren));
                chk("grant_ramWEN", 32'(ramWEN), 32'(e.wen));
                chk("grant_ramaddr", ramaddr, e.addr);
                if (e.wen) chk("grant_ramstore", ramstore, e.store);
            end
        end
        if (!busy) idle_run++;
        for (int c = 0; c < 2; c++) begin
            if ((dREN[c] | dWEN[c]) && !dwait[c]) begin
                done_d[c] = 1'b1;
                n_done++;
                chk($sformatf("dload%0d", c), dload[c], ram_data);
            end
            if (iREN[c] && !iwait[c]) begin
                done_i[c] = 1'b1;
                n_done++;
                chk($sformatf("iload%0d", c), iload[c], ram_data);
            end
        end
        busy_q = busy;
    endtask

    // One clock: served requesters drop their request, the RAM model answers ACCESS after lat BUSY cycles.
    task automatic step();
        @(posedge CLK);
        #1;
        for (int c = 0; c < 2; c++) begin
            if (done_d[c]) begin dREN[c] = 1'b0; dWEN[c] = 1'b0; end
            if (done_i[c]) iREN[c] = 1'b0;
        end
        done_d = '0;
        done_i = '0;
        if (busy && (ramREN || ramWEN)) begin
            if (bcnt >= lat) begin ramstate = ACCESS; bcnt = 0; end
            else begin ramstate = BUSY; bcnt++; end
        end else begin
            ramstate = FREE;
            bcnt = 0;
        end
        @(negedge CLK);
        monitor();
    endtask

    task automatic run_done(input int cnt, input string name);
        int base, cyc;
        base = n_done;
        cyc  = 0;
        while ((n_done - base) < cnt && cyc < 80) begin
            step();
            cyc++;
        end
        chk(name, 32'(n_done - base), 32'(cnt));
    endtask

    task automatic do_reset();
        nRST = 1'b0;
        step();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_owner", 32'(owner), 32'd0);
        chk("rst_ramREN", 32'(ramREN), 32'd0);
        chk("rst_ramWEN", 32'(ramWEN), 32'd0);
        chk("rst_timeout_err", 32'(timeout_err), 32'd0);
        chk("rst_iwait", 32'(iwait), 32'(iREN));
        chk("rst_dwait", 32'(dwait), 32'(dREN | dWEN));
        nRST = 1'b1;
    endtask

    initial begin
        int cyc, base;
        iREN = '0; dREN = '0; dWEN = '0;
        iaddr = '0; daddr = '0; dstore = '0;
        ramstate = FREE;

        vt[0] = mkv(0, 1'b0, 1'b1, 1'b0, 32'h100, 32'h0,        2, 2'd0, 1'b1, 1'b0, 32'h100, 32'h0);
        vt[1] = mkv(1, 1'b0, 1'b1, 1'b1, 32'h200, 32'hDEADBEEF, 1, 2'd2, 1'b0, 1'b1, 32'h200, 32'hDEADBEEF);
        vt[2] = mkv(1, 1'b1, 1'b0, 1'b0, 32'h040, 32'h0,        0, 2'd3, 1'b1, 1'b0, 32'h040, 32'h0);
        vt[3] = mkv(0, 1'b1, 1'b0, 1'b0, 32'h044, 32'h0,        2, 2'd1, 1'b1, 1'b0, 32'h044, 32'h0);
        vt[4] = mkv(0, 1'b0, 1'b0, 1'b1, 32'h010, 32'h12345678, 1, 2'd0, 1'b0, 1'b1, 32'h010, 32'h12345678);

        do_reset();

        // Single requesters: grant shape, completion latency and load forwarding.
        for (int v = 0; v < 5; v++) begin
            lat = vt[v].lat;
            ram_data = 32'hA5A5_0000 + 32'(v);
            if (vt[v].is_i) begin
                iREN[vt[v].core] = 1'b1;
                iaddr[vt[v].core] = vt[v].addr;
            end else begin
                dREN[vt[v].core] = vt[v].ren;
                dWEN[vt[v].core] = vt[v].wen;
                daddr[vt[v].core] = vt[v].addr;
                dstore[vt[v].core] = vt[v].store;
            end
            exp_q.push_back(mkg(vt[v].e_owner, vt[v].e_ren, vt[v].e_wen, vt[v].e_addr, vt[v].e_store));
            base = n_done;
            cyc = 0;
            while (n_done == base && cyc < 20) begin
                step();
                cyc++;
            end
            chk($sformatf("vec%0d_latency", v), 32'(cyc), 32'(vt[v].lat + 1));
            step();
        end

        // All four held from reset: D0, D1, I0, I1 with one IDLE cycle between grants.
        do_reset();
        lat = 1;
        ram_data = 32'h1111_2222;
        iaddr[0] = 32'h1000; iaddr[1] = 32'h2000;
        daddr[0] = 32'h3000; daddr[1] = 32'h4000;
        chk_gap = 1'b1;
        gap_armed = 1'b0;
        dREN = 2'b11;
        iREN = 2'b11;
        exp_q.push_back(mkg(2'd0, 1'b1, 1'b0, 32'h3000, 32'h0));
        exp_q.push_back(mkg(2'd2, 1'b1, 1'b0, 32'h4000, 32'h0));
        exp_q.push_back(mkg(2'd1, 1'b1, 1'b0, 32'h1000, 32'h0));
        exp_q.push_back(mkg(2'd3, 1'b1, 1'b0, 32'h2000, 32'h0));
        run_done(4, "all_held_done");
        chk("all_held_queue", 32'(exp_q.size()), 32'd0);
        chk_gap = 1'b0;
        step();

        // Abort: core 0 completes first, then I1 is granted and drops its request.
        dREN[0] = 1'b1;
        daddr[0] = 32'h50;
        exp_q.push_back(mkg(2'd0, 1'b1, 1'b0, 32'h50, 32'h0));
        run_done(1, "pre_abort_done");
        step();
        lat = 10;
        iREN[1] = 1'b1;
        iaddr[1] = 32'h60;
        exp_q.push_back(mkg(2'd3, 1'b1, 1'b0, 32'h60, 32'h0));
        cyc = 0;
        while (!busy && cyc < 10) begin
            step();
            cyc++;
        end
        chk("abort_granted", 32'(busy), 32'd1);
        iREN[1] = 1'b0;
        #1;
        chk("abort_ramREN", 32'(ramREN), 32'd0);
        chk("abort_ramWEN", 32'(ramWEN), 32'd0);
        chk("abort_iwait", 32'(iwait), 32'd0);
        step();
        chk("abort_idle", 32'(busy), 32'd0);
        lat = 1;
        dREN = 2'b11;
        daddr[0] = 32'h54;
        daddr[1] = 32'h58;
        exp_q.push_back(mkg(2'd2, 1'b1, 1'b0, 32'h58, 32'h0));
        exp_q.push_back(mkg(2'd0, 1'b1, 1'b0, 32'h54, 32'h0));
        run_done(2, "post_abort_done");
        step();

        // Watchdog: TIMEOUT=4, RAM busy for 5 cycles then ACCESS.
        chk("err_before_timeout", 32'(timeout_err), 32'd0);
        lat = 5;
        dREN[0] = 1'b1;
        daddr[0] = 32'h70;
        exp_q.push_back(mkg(2'd0, 1'b1, 1'b0, 32'h70, 32'h0));
        base = n_done;
        for (int g = 1; g <= 6; g++) begin
            step();
            chk($sformatf("timeout_cyc%0d", g), 32'(timeout_err), 32'(g >= 5));
        end
        chk("timeout_completed", 32'(n_done - base), 32'd1);
        step();
        step();
        chk("timeout_sticky", 32'(timeout_err), 32'd1);
        chk("timeout_idle", 32'(busy), 32'd0);

        // Reset in the middle of a grant; afterwards the first tie goes to core 0.
        lat = 10;
        dREN[0] = 1'b1;
        daddr[0] = 32'h80;
        exp_q.push_back(mkg(2'd0, 1'b1, 1'b0, 32'h80, 32'h0));
        step();
        chk("rst_mid_granted", 32'(busy), 32'd1);
        step();
        nRST = 1'b0;
        #1;
        chk("rst_async_busy", 32'(busy), 32'd0);
        chk("rst_async_ramREN", 32'(ramREN), 32'd0);
        do_reset();
        lat = 1;
        dREN[1] = 1'b1;
        daddr[1] = 32'h84;
        exp_q.push_back(mkg(2'd0, 1'b1, 1'b0, 32'h80, 32'h0));
        exp_q.push_back(mkg(2'd2, 1'b1, 1'b0, 32'h84, 32'h0));
        run_done(2, "post_reset_done");
        chk("final_queue", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
